// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux scheduler.
//   N_REQ / SEL_W  : requester count and mux select width
//   state_t        : scheduler FSM states
//   onehot_to_idx  : one-hot grant vector -> binary mux select
package mux4_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker over four requesters.
//   req   : request vector
//   ptr   : highest-priority index; search wraps ptr, ptr+1, ... mod 4
//   mask  : requesters excluded from this pick
//   found : some unmasked request is set
//   idx   : index of the winner (ptr when nothing is found)
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] eligible;
    logic [SEL_W-1:0] cand;

    // Walk from the lowest priority (ptr+3) up to ptr so the last hit,
    // which is the closest to ptr, is the one that sticks.
    always_comb begin
        eligible = req & ~mask;
        found    = 1'b0;
        idx      = ptr;
        cand     = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select of a shared 4:1 single-bit mux.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester request (bit i -> mux input i)
//   last       : per-requester final-beat marker (used only for the holder)
//   sel        : registered mux select = index of the holder
//   gnt        : registered one-hot grant, zero when idle
//   active     : a grant is held
//   beat_cnt   : beats completed in the current grant
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             active,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    state_t           state, stateNext;
    logic [SEL_W-1:0] ptr, ptrNext, selNext;
    logic [N_REQ-1:0] gntNext, pickMask;
    logic [CNT_W-1:0] cntNext;
    logic [SEL_W-1:0] holder, pickIdx;
    logic             pickFound, beat, lastHit, limitHit, relNow;

    // One picker serves both paths: in IDLE nothing is masked, on release
    // the current holder is masked out.
    rr_pick4 uPick (
        .req   (req),
        .ptr   (ptr),
        .mask  (pickMask),
        .found (pickFound),
        .idx   (pickIdx)
    );

    always_comb begin
        holder    = onehot_to_idx(gnt);
        beat      = (state == GRANT) && req[holder];
        lastHit   = beat && last[holder];
        limitHit  = beat && (beat_cnt == LIMIT);
        relNow    = (state == GRANT) && (!req[holder] || lastHit || limitHit);
        pickMask  = (state == GRANT) ? gnt : '0;

        stateNext = state;
        gntNext   = gnt;
        selNext   = sel;
        ptrNext   = ptr;
        cntNext   = beat_cnt;

        unique case (state)
            IDLE: begin
                if (pickFound) begin
                    stateNext = GRANT;
                    gntNext   = N_REQ'(1) << pickIdx;
                    selNext   = pickIdx;
                    ptrNext   = pickIdx + SEL_W'(1);
                    cntNext   = '0;
                end
            end
            GRANT: begin
                if (relNow) begin
                    cntNext = '0;
                    if (pickFound) begin
                        gntNext = N_REQ'(1) << pickIdx;
                        selNext = pickIdx;
                        ptrNext = pickIdx + SEL_W'(1);
                    end else if (limitHit && !lastHit) begin
                        // Burst-limited holder with nobody else waiting keeps
                        // the grant; only its beat count restarts.
                        gntNext = gnt;
                    end else begin
                        stateNext = IDLE;
                        gntNext   = '0;
                    end
                end else if (beat) begin
                    cntNext = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                gntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= stateNext;
            gnt      <= gntNext;
            sel      <= selNext;
            ptr      <= ptrNext;
            beat_cnt <= cntNext;
        end
    end

    assign active = |gnt;

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req8, last8, req2, last2, req1, last1;
    logic [1:0] sel8, sel2, sel1;
    logic [3:0] gnt8, gnt2, gnt1;
    logic       act8, act2, act1;
    logic [7:0] cnt8, cnt2, cnt1;

    int errs = 0;
    int nChk = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_BURST(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .last(last8),
        .sel(sel8), .gnt(gnt8), .active(act8), .beat_cnt(cnt8)
    );
    mux4_rr_sched #(.MAX_BURST(2), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .last(last2),
        .sel(sel2), .gnt(gnt2), .active(act2), .beat_cnt(cnt2)
    );
    mux4_rr_sched #(.MAX_BURST(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .last(last1),
        .sel(sel1), .gnt(gnt1), .active(act1), .beat_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req8 = '0; last8 = '0; req2 = '0; last2 = '0; req1 = '0; last1 = '0;
        step();
        step();
        chk("rst gnt", gnt8, 4'b0000);
        chk("rst sel", sel8, 2'd0);
        chk("rst active", act8, 1'b0);
        chk("rst cnt", cnt8, 8'd0);
        rst_n = 1'b1;

        // Single requester 2, last on its third granted cycle.
        req8 = 4'b0100;
        step();
        chk("single gnt", gnt8, 4'b0100);
        chk("single sel", sel8, 2'd2);
        chk("single active", act8, 1'b1);
        chk("single cnt0", cnt8, 8'd0);
        step();
        chk("single cnt1", cnt8, 8'd1);
        step();
        chk("single cnt2", cnt8, 8'd2);
        last8 = 4'b0100;
        step();
        req8 = '0; last8 = '0;
        chk("single rel gnt", gnt8, 4'b0000);
        chk("single rel active", act8, 1'b0);
        chk("single rel cnt", cnt8, 8'd0);
        chk("single rel sel hold", sel8, 2'd2);

        // Requester 1 alone past the burst limit: grant never drops.
        req8 = 4'b0010;
        step();
        chk("burst gnt0", gnt8, 4'b0010);
        for (int n = 1; n < 20; n++) begin
            step();
            chk($sformatf("burst gnt%0d", n), gnt8, 4'b0010);
            chk($sformatf("burst cnt%0d", n), cnt8, n % 8);
        end
        req8 = '0;
        step();
        chk("burst drop gnt", gnt8, 4'b0000);

        // Holder 3 drops its request while requester 0 rises.
        req8 = 4'b1000;
        step();
        chk("drop hold gnt", gnt8, 4'b1000);
        chk("drop hold sel", sel8, 2'd3);
        step();
        step();
        chk("drop hold cnt", cnt8, 8'd2);
        req8 = 4'b0001;
        step();
        chk("drop new gnt", gnt8, 4'b0001);
        chk("drop new sel", sel8, 2'd0);
        chk("drop new cnt", cnt8, 8'd0);
        step();
        chk("drop next cnt", cnt8, 8'd1);
        req8 = '0;
        step();
        chk("drop idle gnt", gnt8, 4'b0000);

        // Reset during requester 2's burst.
        req8 = 4'b0100;
        step();
        chk("mrst pre gnt", gnt8, 4'b0100);
        step();
        chk("mrst pre cnt", cnt8, 8'd1);
        rst_n = 1'b0;
        step();
        chk("mrst gnt", gnt8, 4'b0000);
        chk("mrst sel", sel8, 2'd0);
        chk("mrst active", act8, 1'b0);
        chk("mrst cnt", cnt8, 8'd0);
        rst_n = 1'b1;
        req8 = 4'b1010;
        step();
        chk("mrst ptr gnt", gnt8, 4'b0010);
        chk("mrst ptr sel", sel8, 2'd1);
        req8 = '0;
        step();

        // Fairness with MAX_BURST=2, all four requesting.
        req2 = 4'b1111;
        step();
        chk("fair gnt0", gnt2, 4'b0001);
        chk("fair cnt0", cnt2, 8'd0);
        for (int n = 1; n < 10; n++) begin
            step();
            chk($sformatf("fair gnt%0d", n), gnt2, 4'b0001 << ((n / 2) % 4));
            chk($sformatf("fair sel%0d", n), sel2, (n / 2) % 4);
            chk($sformatf("fair cnt%0d", n), cnt2, n % 2);
        end
        req2 = '0;
        step();
        chk("fair idle", act2, 1'b0);

        // MAX_BURST=1 with requesters 0 and 2: rotates every cycle.
        req1 = 4'b0101;
        step();
        chk("mb1 sel0", sel1, 2'd0);
        for (int n = 1; n < 7; n++) begin
            step();
            chk($sformatf("mb1 sel%0d", n), sel1, (n % 2) * 2);
            chk($sformatf("mb1 gnt%0d", n), gnt1, (n % 2) ? 4'b0100 : 4'b0001);
            chk($sformatf("mb1 cnt%0d", n), cnt1, 8'd0);
        end
        req1 = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, nChk);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares one 4:1 single-bit mux among four requesters by driving its 2-bit select. Each requester raises a request, streams one bit per granted cycle through the mux, and is released on its own `last`, on dropping its request, or when a burst limit is reached. Sits directly in front of the mux select inputs; the mux data path itself is outside this block.

## Interface
- `MAX_BURST`, 8, maximum granted beats per grant (legal range 1..255).
- `CNT_W`, 8, burst counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request per requester; bit i maps to mux input i (sel = i).
- `last`  in  4  final-beat marker per requester; only meaningful with `req[i]` and `gnt[i]`.
- `sel`  out  2  mux select, registered; equals index of granted requester.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `active`  out  1  high while any grant is held (equals |gnt).
- `beat_cnt`  out  CNT_W  beats completed in the current grant, registered.

## Operation
- Reset (rst_n=0 at a rising edge): `gnt`=0, `sel`=0, `active`=0, `beat_cnt`=0, state IDLE, priority pointer `ptr`=0 (requester 0 highest).
- Arbitration: search `req` starting at `ptr`, wrapping 0..3; the first set bit wins. After granting requester g, `ptr` becomes (g+1) mod 4.
- States:
  - IDLE: if `req`≠0, grant the winner → GRANT; otherwise stay.
  - GRANT (holder g): a beat occurs in each cycle with `req[g]`=1; each beat increments `beat_cnt`.
- Release conditions in GRANT, evaluated each cycle:
  - `req[g]`=1 and `last[g]`=1 (final beat counts).
  - `req[g]`=0 (no beat).
  - Beat with `beat_cnt`=MAX_BURST-1 (burst limit).
- On release:
  - Re-arbitrate in the same cycle over `req` with g masked out. Because `ptr` is already g+1, g has lowest priority anyway.
  - Winner found: switch `gnt`/`sel` at the next edge and clear `beat_cnt`; stay in GRANT.
  - No other requester: go to IDLE, `gnt`=0, `beat_cnt`=0. `sel` holds its last value.
  - A requester released by the burst limit that keeps `req` high is re-granted only after every other active requester has been served (or immediately, if it is alone).
- `last` is ignored for any non-granted bit.
- `sel` changes only together with a new grant, never while a grant is held.

## Timing
- Grant latency: `req` sampled high at edge k while IDLE → `gnt`/`sel` valid after edge k (cycle k+1). First beat is in cycle k+1.
- Back-to-back handoff has zero bubble cycles: final beat of g in cycle n, next holder's first beat in cycle n+1.
- MAX_BURST=1: every beat releases; with several requesters the grant rotates every cycle.
- Reset mid-grant: outputs return to reset values after the edge where rst_n=0. No beat is counted in that cycle.
- Simultaneous `last[g]` and burst limit: one release, identical behaviour.
- `req[g]` dropping in the same cycle another requester rises: that requester can win in the same re-arbitration.

## Structure
- Package `mux4_sched_pkg` holds:
  - state enum {IDLE, GRANT};
  - constants N_REQ=4 and SEL_W=2;
  - function `onehot_to_idx`.
- Sub-module `rr_pick4`: combinational rotate-priority picker. Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`. Outputs: `found`, `idx[1:0]`. Instantiated once and used for both the IDLE and release paths.
- Top-level contains the state register, the grant/sel/ptr registers and the beat counter.

## Test plan
- Reset then single requester: `req`=4'b0100 held, `last` pulsed on the 3rd granted cycle → `gnt`=4'b0100 and `sel`=2 from cycle 1; released after 3 beats; IDLE with `gnt`=0.
- Fairness: `req`=4'b1111 held, `last`=0, MAX_BURST=2 → grant order 0,1,2,3,0,… with 2 beats each and no idle cycles; `beat_cnt` goes 0,1,0,1…
- Burst limit alone: only `req[1]`=1 for 20 cycles, MAX_BURST=8 → grant held continuously; `beat_cnt` wraps 0..7 each 8 beats; `gnt` never drops.
- Request drop: holder 3 deasserts `req[3]` mid-burst while `req[0]`=1 → next cycle `gnt`=4'b0001, `sel`=0, `beat_cnt`=0; the drop cycle adds no beat.
- Reset mid-grant: `rst_n`=0 for one edge during holder 2's burst → `gnt`=0, `sel`=0, `active`=0, `ptr`=0. Afterwards, with `req`=4'b1010, the first grant goes to requester 1.
- MAX_BURST=1 with `req`=4'b0101 → grant alternates 0,2,0,2 every cycle; `sel` toggles 0/2.
